// File: rtl/dev_intercon_v2_if.sv
// rtl/dev_intercon_v2_if.sv - CPU-side and target-side bus bundle for dev_intercon_v2
interface dev_intercon_v2_if #(
    parameter int NS       = 4,
    parameter int MASK_LEN = 8
);
    logic                   i_stb;
    logic                   i_rw;
    logic [31:0]            i_addr;
    logic [31:0]            i_dtw;
    logic                   o_ack;
    logic                   o_err;
    logic [31:0]            o_dtr;
    logic [NS-1:0]          o_stb;
    logic [NS-1:0]          i_ack;
    logic [NS*32-1:0]       i_dtr;
    logic [MASK_LEN-1:0]    o_addr;
    logic                   o_rw;
    logic [31:0]            o_dtw;
    logic                   sstb;
    logic                   sack;
    logic [31:0]            sdtr;
    logic                   estb;
    logic                   eack;
    logic [31:0]            edtr;

    // Interconnect view: serves the CPU, drives every target
    modport slave (
        input  i_stb, i_rw, i_addr, i_dtw, i_ack, i_dtr, sack, sdtr, eack, edtr,
        output o_ack, o_err, o_dtr, o_stb, o_addr, o_rw, o_dtw, sstb, estb
    );

    // Environment view: CPU master plus the targets
    modport master (
        output i_stb, i_rw, i_addr, i_dtw, i_ack, i_dtr, sack, sdtr, eack, edtr,
        input  o_ack, o_err, o_dtr, o_stb, o_addr, o_rw, o_dtw, sstb, estb
    );
endinterface

// File: rtl/dev_intercon_v2.sv
// rtl/dev_intercon_v2.sv - CPU bus interconnect to MMIO slaves, SRAM and external bus
module dev_intercon_v2 #(
    parameter int                   NS       = 4,
    parameter int                   MASK_LEN = 8,
    parameter logic [NS*MASK_LEN-1:0] BASE   = '0,
    parameter logic [NS*MASK_LEN-1:0] MASK   = '0,
    parameter logic [NS-1:0]        PRIV     = '0,
    parameter int                   LIMITS   = 12,
    parameter int                   TIMEOUT  = 16,
    parameter int                   TO_BITS  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              userbit,
    dev_intercon_v2_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {TGT_MMIO, TGT_SRAM, TGT_EXT} tgt_t;

    state_t              state_q, state_d;
    tgt_t                tgt_q, tgt_d;
    logic [NS-1:0]       sel_q, sel_d;
    logic                err_q, err_d;
    logic [TO_BITS-1:0]  cnt_q, cnt_d;
    logic [MASK_LEN-1:0] addr_q, addr_d;
    logic                rw_q, rw_d;
    logic [31:0]         dtw_q, dtw_d;
    logic [31:0]         dtr_q, dtr_d;

    tgt_t                dec_tgt;
    logic [NS-1:0]       dec_sel;
    logic                dec_err;
    logic [MASK_LEN-1:0] off;
    logic                sel_ack;
    logic [31:0]         sel_dtr;

    // Address decode; slave i sits at bit NS-1-i so slave 0 is the MSB
    always_comb begin
        dec_tgt = TGT_EXT;
        dec_sel = '0;
        dec_err = 1'b0;
        off     = bus.i_addr[MASK_LEN-1:0];
        if (&bus.i_addr[31:MASK_LEN]) begin
            dec_tgt = TGT_MMIO;
            // Walk from the highest index down so the lowest matching index wins
            for (int i = NS-1; i >= 0; i--) begin
                if ((off & MASK[(NS-1-i)*MASK_LEN +: MASK_LEN]) ==
                    BASE[(NS-1-i)*MASK_LEN +: MASK_LEN]) begin
                    dec_sel = '0;
                    dec_sel[NS-1-i] = 1'b1;
                end
            end
            dec_err = (dec_sel == '0) || ((|(dec_sel & PRIV)) && userbit);
        end else if (bus.i_addr[31:LIMITS] == '0) begin
            dec_tgt = TGT_SRAM;
        end
    end

    // Ack and read data of the latched target only
    always_comb begin
        sel_ack = 1'b0;
        sel_dtr = '0;
        case (tgt_q)
            TGT_MMIO: begin
                sel_ack = |(bus.i_ack & sel_q);
                for (int i = 0; i < NS; i++) begin
                    if (sel_q[i]) sel_dtr = sel_dtr | bus.i_dtr[i*32 +: 32];
                end
            end
            TGT_SRAM: begin
                sel_ack = bus.sack;
                sel_dtr = bus.sdtr;
            end
            TGT_EXT: begin
                sel_ack = bus.eack;
                sel_dtr = bus.edtr;
            end
            default: begin
                sel_ack = 1'b0;
                sel_dtr = '0;
            end
        endcase
    end

    // Transaction FSM: latch request, strobe once, wait for ack or timeout, respond
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        sel_d   = sel_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        dtw_d   = dtw_q;
        dtr_d   = dtr_q;
        case (state_q)
            IDLE: begin
                if (bus.i_stb) begin
                    tgt_d  = dec_tgt;
                    sel_d  = dec_sel;
                    err_d  = dec_err;
                    addr_d = off;
                    rw_d   = bus.i_rw;
                    dtw_d  = bus.i_dtw;
                    if (dec_err) begin
                        dtr_d   = '0;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // An ack always beats a timeout landing in the same cycle
                if (sel_ack) begin
                    dtr_d   = rw_q ? 32'h0 : sel_dtr;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == TO_BITS'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        dtr_d   = '0;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tgt_q   <= TGT_MMIO;
            sel_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            dtw_q   <= '0;
            dtr_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            dtw_q   <= dtw_d;
            dtr_q   <= dtr_d;
        end
    end

    assign bus.o_ack  = (state_q == RESP);
    assign bus.o_err  = (state_q == RESP) && err_q;
    assign bus.o_dtr  = dtr_q;
    assign bus.o_stb  = ((state_q == ISSUE) && (tgt_q == TGT_MMIO)) ? sel_q : '0;
    assign bus.sstb   = (state_q == ISSUE) && (tgt_q == TGT_SRAM);
    assign bus.estb   = (state_q == ISSUE) && (tgt_q == TGT_EXT);
    assign bus.o_addr = addr_q;
    assign bus.o_rw   = rw_q;
    assign bus.o_dtw  = dtw_q;

endmodule

// File: tb/tb_dev_intercon_v2.sv
// tb/tb_dev_intercon_v2.sv - self-checking bench for dev_intercon_v2
module tb_dev_intercon_v2;

    localparam int          NS      = 4;
    localparam int          ML      = 8;
    localparam int          TIMEOUT = 16;
    localparam logic [31:0] BASE_P  = {8'h00, 8'h20, 8'h40, 8'h60};
    localparam logic [31:0] MASK_P  = {4{8'hE0}};
    localparam logic [3:0]  PRIV_P  = 4'b0100;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic userbit = 1'b0;

    always #5 clk = ~clk;

    dev_intercon_v2_if #(.NS(NS), .MASK_LEN(ML)) bus ();

    dev_intercon_v2 #(
        .NS(NS), .MASK_LEN(ML), .BASE(BASE_P), .MASK(MASK_P), .PRIV(PRIV_P),
        .LIMITS(12), .TIMEOUT(TIMEOUT), .TO_BITS(8)
    ) dut (
        .clk(clk), .reset(reset), .userbit(userbit), .bus(bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    int base_t[4] = '{'h00, 'h20, 'h40, 'h60};
    int priv_t[4] = '{0, 1, 0, 0};

    typedef struct {
        logic [31:0] addr;
        logic        rw;
        logic        user;
        logic [31:0] dtw;
        int          dly;
        logic [31:0] rdata;
        logic [5:0]  e_pat;
        int          e_lat;
        logic        e_err;
        logic [31:0] e_dtr;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Target-side drive; pattern bits {slave0..slave3, sram, ext}
    task automatic drive(input logic [5:0] a, input logic [5:0] sel, input logic [31:0] rd);
        logic [31:0] d[6];
        for (int j = 0; j < 6; j++) d[j] = (a[j] && sel[j]) ? rd : $urandom;
        bus.i_ack = a[5:2];
        bus.sack  = a[1];
        bus.eack  = a[0];
        bus.i_dtr = {d[5], d[4], d[3], d[2]};
        bus.sdtr  = d[1];
        bus.edtr  = d[0];
    endtask

    // Reference: which target should see the strobe, or decode error
    function automatic void model(input logic [31:0] a, input logic u,
                                  output logic [5:0] pat, output bit derr);
        int hit;
        pat  = '0;
        derr = 1'b0;
        hit  = -1;
        if ((a >> 8) == 32'h00FF_FFFF) begin
            for (int i = 0; i < 4; i++)
                if (hit < 0 && ((a & 32'hFF) & 32'hE0) == base_t[i]) hit = i;
            if (hit < 0 || (priv_t[hit] != 0 && u)) derr = 1'b1;
            else pat = 6'b100000 >> hit;
        end else if (a < 32'd4096) begin
            pat = 6'b000010;
        end else begin
            pat = 6'b000001;
        end
    endfunction

    // One transaction; cycle 0 is the i_stb cycle, called just after a negedge
    task automatic run_txn(input logic [31:0] addr, input logic rw, input logic user,
                           input logic [31:0] dtw, input int dly, input logic [31:0] rdata,
                           output logic [5:0] seen, output int scnt, output int ack_cyc,
                           output logic err, output logic [31:0] dtr, output logic [7:0] l_addr,
                           output logic l_rw, output logic [31:0] l_dtw, output int extra);
        logic [5:0] cur, a;
        int s;
        seen = '0; scnt = 0; ack_cyc = -1; err = 1'bx; dtr = 'x;
        l_addr = 'x; l_rw = 1'bx; l_dtw = 'x; extra = 0; s = -1;
        bus.i_stb = 1'b1; bus.i_rw = rw; bus.i_addr = addr; bus.i_dtw = dtw; userbit = user;
        @(posedge clk);
        @(negedge clk);
        bus.i_stb = 1'b0; bus.i_rw = 1'($urandom); bus.i_addr = $urandom; bus.i_dtw = $urandom;
        for (int n = 1; n <= 40; n++) begin
            cur = {bus.o_stb, bus.sstb, bus.estb};
            if (cur != '0) begin
                seen = seen | cur;
                scnt++;
                if (s < 0) begin
                    s = n; l_addr = bus.o_addr; l_rw = bus.o_rw; l_dtw = bus.o_dtw;
                end
            end
            if (bus.o_ack) begin
                if (ack_cyc < 0) begin
                    ack_cyc = n; err = bus.o_err; dtr = bus.o_dtr;
                end else begin
                    extra++;
                end
            end
            if (ack_cyc >= 0 && n > ack_cyc + 1) break;
            a = '0;
            if (n >= 2) a = 6'($urandom) & ~seen;
            if (s > 0 && n == s + dly) a = a | seen;
            drive(a, seen, rdata);
            @(negedge clk);
        end
        drive('0, '0, '0);
    endtask

    task automatic check_txn(input string tag, input logic [31:0] addr, input logic rw,
                             input logic user, input logic [31:0] dtw, input int dly,
                             input logic [31:0] rdata, input logic [5:0] e_pat,
                             input int e_lat, input logic e_err, input logic [31:0] e_dtr);
        logic [5:0] seen; int scnt, ack_cyc, extra; logic err; logic [31:0] dtr, l_dtw;
        logic [7:0] l_addr; logic l_rw;
        run_txn(addr, rw, user, dtw, dly, rdata, seen, scnt, ack_cyc, err, dtr, l_addr, l_rw, l_dtw, extra);
        chk({tag, " strobe"}, 32'(seen), 32'(e_pat));
        chk({tag, " strobe_cycles"}, scnt, (e_pat != '0) ? 1 : 0);
        chk({tag, " ack_latency"}, ack_cyc, e_lat);
        chk({tag, " o_err"}, 32'(err), 32'(e_err));
        chk({tag, " o_dtr"}, dtr, e_dtr);
        chk({tag, " extra_ack"}, extra, 0);
        if (e_pat != '0) begin
            chk({tag, " o_addr"}, 32'(l_addr), 32'(addr[7:0]));
            chk({tag, " o_rw"}, 32'(l_rw), 32'(rw));
            chk({tag, " o_dtw"}, l_dtw, dtw);
        end
    endtask

    task automatic model_txn(input string tag, input logic [31:0] addr, input logic rw,
                             input logic user, input int dly);
        logic [5:0] pat; bit derr; logic [31:0] rd, dtw; int lat; logic e;
        rd = $urandom; dtw = $urandom;
        model(addr, user, pat, derr);
        lat = derr ? 1 : ((dly <= TIMEOUT - 1) ? dly + 2 : TIMEOUT + 1);
        e   = derr || (dly > TIMEOUT - 1);
        check_txn(tag, addr, rw, user, dtw, dly, rd, pat, lat, e, (e || rw) ? 32'h0 : rd);
    endtask

    initial begin
        int acks;
        logic [31:0] a;
        int dly;

        tbl[0]  = '{32'hFFFFFF24, 1'b0, 1'b0, 32'h0,        1,  32'h12345678, 6'b010000, 3,  1'b0, 32'h12345678};
        tbl[1]  = '{32'hFFFFFF24, 1'b0, 1'b1, 32'h0,        1,  32'h12345678, 6'b000000, 1,  1'b1, 32'h0};
        tbl[2]  = '{32'hFFFFFFF0, 1'b0, 1'b0, 32'h0,        1,  32'h11111111, 6'b000000, 1,  1'b1, 32'h0};
        tbl[3]  = '{32'h00000100, 1'b1, 1'b0, 32'hCAFEBABE, 2,  32'hDEADBEEF, 6'b000010, 4,  1'b0, 32'h0};
        tbl[4]  = '{32'h00010000, 1'b0, 1'b0, 32'h0,        99, 32'h0,        6'b000001, 17, 1'b1, 32'h0};
        tbl[5]  = '{32'h00010000, 1'b0, 1'b0, 32'h0,        15, 32'hA5A5A5A5, 6'b000001, 17, 1'b0, 32'hA5A5A5A5};
        tbl[6]  = '{32'h00010000, 1'b0, 1'b0, 32'h0,        16, 32'h5A5A5A5A, 6'b000001, 17, 1'b1, 32'h0};
        tbl[7]  = '{32'hFFFFFF05, 1'b0, 1'b1, 32'h0,        3,  32'h11112222, 6'b100000, 5,  1'b0, 32'h11112222};
        tbl[8]  = '{32'hFFFFFF7F, 1'b1, 1'b1, 32'h01020304, 1,  32'h33334444, 6'b000100, 3,  1'b0, 32'h0};
        tbl[9]  = '{32'h00000FFF, 1'b0, 1'b0, 32'h0,        1,  32'h0F0F0F0F, 6'b000010, 3,  1'b0, 32'h0F0F0F0F};
        tbl[10] = '{32'h00001000, 1'b0, 1'b0, 32'h0,        1,  32'h77778888, 6'b000001, 3,  1'b0, 32'h77778888};
        tbl[11] = '{32'hFFFFFE24, 1'b0, 1'b0, 32'h0,        2,  32'h9999AAAA, 6'b000001, 4,  1'b0, 32'h9999AAAA};
        tbl[12] = '{32'hFFFFFF44, 1'b0, 1'b1, 32'h0,        1,  32'hBBBBCCCC, 6'b001000, 3,  1'b0, 32'hBBBBCCCC};

        bus.i_stb = 1'b0; bus.i_rw = 1'b0; bus.i_addr = '0; bus.i_dtw = '0;
        drive('0, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset o_ack", 32'(bus.o_ack), 32'h0);
        chk("reset o_err", 32'(bus.o_err), 32'h0);
        chk("reset o_dtr", bus.o_dtr, 32'h0);
        chk("reset strobes", 32'({bus.o_stb, bus.sstb, bus.estb}), 32'h0);
        chk("reset o_addr", 32'(bus.o_addr), 32'h0);
        chk("reset o_rw", 32'(bus.o_rw), 32'h0);
        chk("reset o_dtw", bus.o_dtw, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++)
            check_txn($sformatf("vec%0d", i), tbl[i].addr, tbl[i].rw, tbl[i].user, tbl[i].dtw,
                      tbl[i].dly, tbl[i].rdata, tbl[i].e_pat, tbl[i].e_lat, tbl[i].e_err, tbl[i].e_dtr);

        // Late eack after a timeout must not produce a second completion
        check_txn("timeout_ext", 32'h00020000, 1'b0, 1'b0, 32'h0, 99, 32'h0, 6'b000001, 17, 1'b1, 32'h0);
        drive(6'b000001, 6'b000001, 32'hFEEDFACE);
        acks = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            drive('0, '0, '0);
            acks += int'(bus.o_ack);
        end
        chk("late_eack no_ack", acks, 0);

        // Reset while waiting on SRAM, then an ack: no completion, clean restart
        bus.i_stb = 1'b1; bus.i_rw = 1'b0; bus.i_addr = 32'h00000200; userbit = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.i_stb = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        acks = 0;
        for (int n = 0; n < 4; n++) begin
            drive(6'b000010, 6'b000010, 32'h55555555);
            acks += int'(bus.o_ack) + int'(bus.sstb);
            @(negedge clk);
        end
        drive('0, '0, '0);
        chk("reset_wait no_ack", acks, 0);
        chk("reset_wait o_dtr", bus.o_dtr, 32'h0);
        check_txn("after_reset", 32'h00000204, 1'b0, 1'b0, 32'h0, 2, 32'h600DF00D, 6'b000010, 4, 1'b0, 32'h600DF00D);

        // Randomized traffic against the reference model
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0: a = {24'hFFFFFF, 8'($urandom)};
                1: a = 32'($urandom_range(0, 4095));
                2: begin
                    a = $urandom;
                    if ((a >> 8) == 32'h00FF_FFFF || a < 32'd4096) a = a ^ 32'h8000_0000;
                end
                default: a = ($urandom_range(0, 1) != 0) ? 32'h00001000 : 32'hFFFFFF9F;
            endcase
            dly = ($urandom_range(0, 9) < 7) ? int'($urandom_range(1, 4)) : int'($urandom_range(13, 17));
            model_txn($sformatf("rand%0d", i), a, 1'($urandom), 1'($urandom), dly);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
